// File: rtl/fib_pkg.sv
// fib_pkg: shared FSM state encoding and ALU opcode constants for fib_seq
package fib_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_XOR = 5'd5;
    localparam logic [4:0] ALU_NOR = 5'd6;
endpackage

// File: rtl/fib_seq.sv
// fib_seq: Fibonacci-style term generator f(n) that borrows an external ALU for every addition.
// Ports: clk/rst_n (async active-low reset); start, f0, f1, n request a computation in IDLE;
// alu_a/alu_b/alu_op drive the external ALU and alu_out is its same-cycle result;
// busy is high outside IDLE; res/res_valid/res_ready is the result handshake; ovf is the
// sticky signed-overflow flag, only live when FIB_OVF_DETECT_EN is defined (tied 0 otherwise).
module fib_seq
    import fib_pkg::*;
#(
    parameter int NW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [31:0] f0,
    input  logic signed [31:0] f1,
    input  logic [NW-1:0]      n,
    output logic signed [31:0] alu_a,
    output logic signed [31:0] alu_b,
    output logic [4:0]         alu_op,
    input  logic [31:0]        alu_out,
    output logic               busy,
    output logic [31:0]        res,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               ovf
);
    state_t             state_q, state_d;
    logic signed [31:0] a_q, a_d, b_q, b_d;
    logic [NW-1:0]      cnt_q, cnt_d;
    logic [31:0]        res_q, res_d;
    logic               run, accept;
    assign run       = state_q == RUN;
    assign accept    = state_q == IDLE && start;
    assign alu_a     = run ? a_q : '0;
    assign alu_b     = run ? b_q : '0;
    assign alu_op    = run ? ALU_ADD : ALU_NOP;
    assign busy      = state_q != IDLE;
    assign res_valid = state_q == DONE;
    assign res       = res_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (accept) begin
            a_d     = f0;
            b_d     = f1;
            cnt_d   = n - NW'(1);
            state_d = n < NW'(2) ? DONE : RUN;
            res_d   = n < NW'(2) ? (n == '0 ? f0 : f1) : res_q;
        end else if (run) begin
            a_d   = b_q;
            b_d   = alu_out;
            cnt_d = cnt_q - NW'(1);
            // cnt==1 marks the addition that produces f(n) itself
            if (cnt_q == NW'(1)) begin
                res_d   = alu_out;
                state_d = DONE;
            end
        end else if (res_valid && res_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end
`ifdef FIB_OVF_DETECT_EN
    logic ovf_q, ovf_d;
    // Signed overflow: operands agree in sign but the sum does not
    always_comb ovf_d = accept ? 1'b0 :
                        (run && a_q[31] == b_q[31] && alu_out[31] != a_q[31]) ? 1'b1 : ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_fib_seq.sv
// tb_fib_seq: scoreboard bench for fib_seq with a behavioural ALU wired alongside.
module tb_fib_seq;
    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } exp_t;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [31:0] f0 = '0, f1 = '0;
    logic [7:0]         n = '0;
    logic signed [31:0] alu_a, alu_b;
    logic [4:0]         alu_op;
    logic [31:0]        alu_out, res;
    logic               busy, res_valid, ovf;
    logic               res_ready = 1'b0;
    logic               watch = 1'b0, saw_op = 1'b0;
    int                 checks = 0, errors = 0;
    exp_t               sb[$];
    fib_seq #(.NW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f0(f0), .f1(f1), .n(n),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .busy(busy), .res(res), .res_valid(res_valid), .res_ready(res_ready), .ovf(ovf)
    );
    assign alu_out = alu_op == 5'd1 ? alu_a + alu_b : 32'd0;
    always #5 clk = ~clk;
    always @(negedge clk) if (watch && (alu_op != 5'd0 || alu_a != 0 || alu_b != 0)) saw_op = 1'b1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [31:0] x0, input logic [31:0] x1, input int nn);
        exp_t        e;
        logic [31:0] p, q, s;
        p = x0;
        q = x1;
        e.ovf = 1'b0;
        e.lat = nn < 2 ? 1 : nn;
        for (int i = 2; i <= nn; i++) begin
            s = p + q;
            if (p[31] == q[31] && s[31] != p[31]) e.ovf = 1'b1;
            p = q;
            q = s;
        end
        e.res = nn == 0 ? x0 : q;
`ifndef FIB_OVF_DETECT_EN
        e.ovf = 1'b0;
`endif
        return e;
    endfunction
    task automatic run(input logic [31:0] a0, input logic [31:0] a1, input int nn,
                       input int hold, input bit poke);
        exp_t e;
        int   lat;
        @(negedge clk);
        f0 = a0;
        f1 = a1;
        n = 8'(nn);
        start = 1'b1;
        sb.push_back(model(a0, a1, nn));
        @(negedge clk);
        start = 1'b0;
        n = 8'd3;
        lat = 1;
        while (!res_valid && lat < 400) begin
            start = poke && lat == 3;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!res_valid) begin
            chk("timeout", 32'(lat), 32'(sb[0].lat));
            sb.delete();
            return;
        end
        e = sb.pop_front();
        chk("res", res, e.res);
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("latency", 32'(lat), 32'(e.lat));
        chk("done_alu", {alu_a[26:0], alu_op}, 32'd0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold", {res_valid, busy, 30'd0} ^ res, {2'b11, 30'd0} ^ e.res);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("to_idle", {30'd0, busy, res_valid}, 32'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out", {res[29:0], res_valid, busy}, 32'd0);
        chk("rst_alu", {alu_a[25:0], ovf, alu_op}, 32'd0);
        rst_n = 1'b1;
        run(32'd0, 32'd1, 10, 0, 1'b0);
        watch = 1'b1;
        run(32'd7, 32'd9, 0, 0, 1'b0);
        run(32'd7, 32'd9, 1, 0, 1'b0);
        watch = 1'b0;
        chk("n01_alu_quiet", 32'(saw_op), 32'd0);
        run(32'd2, 32'd3, 4, 3, 1'b0);
        run(32'h40000000, 32'h40000000, 2, 0, 1'b0);
        run(32'd1, 32'd1, 3, 0, 1'b0);
        run(-32'sd5, 32'd3, 7, 1, 1'b0);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 40, 0, 1'b0);
        run(32'd0, 32'd1, 10, 0, 1'b1);
        run(32'd0, 32'd1, 255, 0, 1'b0);
        @(negedge clk);
        f0 = 32'd0;
        f1 = 32'd1;
        n = 8'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrun_rst_out", {res[28:0], res_valid, busy, ovf}, 32'd0);
        chk("midrun_rst_alu", {alu_a[26:0], alu_op}, 32'd0);
        chk("midrun_rst_b", alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("no_result", {30'd0, res_valid, busy}, 32'd0);
        run(32'd0, 32'd1, 5, 0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fib_seq.md
FIB_SEQ -- requirements
Module: fib_seq

Interface
REQ-001 SHALL have parameter NW, default 8, width of the iteration-count input n.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-005 SHALL have port f0, input signed, 32, seed term f(0).
REQ-006 SHALL have port f1, input signed, 32, seed term f(1).
REQ-007 SHALL have port n, input, NW, index of the requested term.
REQ-008 SHALL have port alu_a, output signed, 32, left operand to the downstream ALU.
REQ-009 SHALL have port alu_b, output signed, 32, right operand to the downstream ALU.
REQ-010 SHALL have port alu_op, output, 5, ALU opcode (0 = NOP, 1 = ADD).
REQ-011 SHALL have port alu_out, input, 32, combinational result returned by the ALU in the same cycle.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port res, output, 32, f(n).
REQ-014 SHALL have port res_valid, output, 1, res is valid.
REQ-015 SHALL have port res_ready, input, 1, consumer accepts res.
REQ-016 SHALL have port ovf, output, 1, sticky signed-overflow flag for the current computation.

Function
REQ-017 SHALL implement the recurrence f(i) = f(i-1) + f(i-2), with all additions performed by the external ALU using alu_op = 1.
REQ-018 SHALL implement the states IDLE, RUN and DONE, encoded per the fib_pkg state enum.
REQ-019 SHALL, in IDLE with start=1, latch a<=f0, b<=f1 and cnt<=n-1, clear ovf, and go to RUN if n>=2.
REQ-020 SHALL, in IDLE with start=1 and n<2, go directly to DONE with res = (n==0 ? f0 : f1).
REQ-021 SHALL, in each RUN cycle, drive alu_a=a, alu_b=b and alu_op=1, then update a<=b, b<=alu_out and cnt<=cnt-1.
REQ-022 SHALL, in the RUN cycle where cnt==1, capture res<=alu_out and go to DONE.
REQ-023 SHALL give latency from the start-accept edge to res_valid of n cycles for n>=2 and 1 cycle for n<2.
REQ-024 SHALL drive alu_op=0 and alu_a=alu_b=0 in IDLE and DONE.
REQ-025 SHALL hold res_valid=1 and res stable in DONE until res_ready=1, then go to IDLE on that edge.
REQ-026 SHALL accept a new start no earlier than the cycle after the return to IDLE.
REQ-027 SHALL ignore start while busy=1, with no effect on state or outputs.
REQ-028 SHALL wrap 32-bit sums modulo 2^32.
REQ-029 SHALL accept n = 2^NW-1 and complete in exactly 2^NW-1 cycles.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-RUN, immediately enter IDLE.
REQ-031 SHALL, on reset, clear a, b, cnt, res, res_valid, busy, ovf, alu_a, alu_b and alu_op to 0.
REQ-032 SHALL discard any in-progress computation on reset without producing a result.

Configuration
REQ-033 SHALL, with FIB_OVF_DETECT_EN defined, set ovf when any RUN addition has sign(a)==sign(b) and sign(alu_out)!=sign(a).
REQ-034 SHALL, with FIB_OVF_DETECT_EN defined, hold ovf through DONE and clear it on the next start accept.
REQ-035 SHALL, without FIB_OVF_DETECT_EN, keep the ovf port present and tied to 0, with no detection logic.

Structure
REQ-036 SHALL take the state enum (IDLE/RUN/DONE) and the ALU opcode constants ALU_NOP=0, ALU_ADD=1, ALU_SUB=2, ALU_AND=3, ALU_OR=4, ALU_XOR=5, ALU_NOR=6 from shared package fib_pkg.
REQ-037 SHALL NOT instantiate the ALU; the ALU is wired alongside at the parent level, and fib_seq has no sub-module.

Verification
REQ-038 SHALL cover: f0=0, f1=1, n=10, start at T -> res=55, res_valid rising at T+10, ovf=0.
REQ-039 SHALL cover: n=0 -> res=f0 at T+1; n=1 -> res=f1 at T+1; alu_op stays 0 throughout.
REQ-040 SHALL cover: res_ready held low 3 cycles in DONE -> res and res_valid stable, then IDLE on the first ready edge.
REQ-041 SHALL cover: f0=f1=0x40000000, n=2 -> res=0x80000000; ovf=1 with FIB_OVF_DETECT_EN, ovf=0 without.
REQ-042 SHALL cover: start pulsed during RUN is ignored; rst_n low at mid-RUN cycle 4 -> all outputs 0 at once, then a fresh n=5 run -> res=5.
